// File: rtl/vga_sync_rx.sv
// vga_sync_rx: recovers pixel/line coordinates from an incoming active-low
// HS/VS pair, measures line and frame lengths, and runs a lock FSM that
// reports lock status, a per-frame strobe and a saturating timing-error count.
module vga_sync_rx #(
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int H_ACT       = 640,
  parameter int H_TOTAL     = 800,
  parameter int V_BP        = 33,
  parameter int V_ACT       = 480,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       iclk,
  input  logic       iRST,
  input  logic       iHS,
  input  logic       iVS,
  output logic [9:0] oX,
  output logic [9:0] oY,
  output logic       oActive,
  output logic       oLocked,
  output logic       oFrame,
  output logic [9:0] oHLen,
  output logic [9:0] oVLen,
  output logic [7:0] oErrCnt
);

  // VS pulse is fixed at 2 lines, so active video starts at V_SYNC+V_BP
  localparam int         V_SYNC    = 2;
  localparam int         GW        = $clog2(LOCK_FRAMES + 1);
  localparam logic [9:0] CNT_MAX   = 10'h3FF;
  localparam logic [9:0] X_FIRST   = 10'(H_SYNC + H_BP);
  localparam logic [9:0] X_LAST    = 10'(H_SYNC + H_BP + H_ACT - 1);
  localparam logic [9:0] Y_FIRST   = 10'(V_SYNC + V_BP);
  localparam logic [9:0] Y_LAST    = 10'(V_SYNC + V_BP + V_ACT - 1);
  localparam logic [9:0] H_LEN     = 10'(H_TOTAL);
  localparam logic [9:0] V_LEN     = 10'(V_TOTAL);
  localparam logic [GW-1:0] GOOD_LOCK = GW'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  state_t        state_q;
  logic [GW-1:0] good_q;
  logic          first_q;
  logic          err_seen_q;
  logic          hs_q, vs_q;
  logic [9:0]    hcnt_q, vcnt_q;
  logic [9:0]    x_q, y_q, hlen_q, vlen_q;
  logic          active_q, locked_q, frame_q;
  logic [7:0]    errcnt_q;

  logic          hs_edge, vs_edge;
  logic [9:0]    hcnt_inc, vcnt_inc, px, vlen_meas;
  logic          check_en, timeout, line_err, frame_err, in_win;
  logic [GW-1:0] good_inc;
  logic [7:0]    err_inc;

  assign hs_edge   = ~iHS & hs_q;
  assign vs_edge   = ~iVS & vs_q;
  assign hcnt_inc  = (hcnt_q == CNT_MAX) ? CNT_MAX : hcnt_q + 10'd1;
  assign vcnt_inc  = (vcnt_q == CNT_MAX) ? CNT_MAX : vcnt_q + 10'd1;
  // Pixel index of the current sample; the HS edge sample is pixel 0
  assign px        = hs_edge ? 10'd0 : hcnt_inc;
  // A coincident HS edge closes the last line of the frame
  assign vlen_meas = hs_edge ? vcnt_inc : vcnt_q;

  assign check_en  = (state_q == TRACK) || (state_q == LOCKED);
  assign timeout   = check_en && (hcnt_q == CNT_MAX);
  // The first line after entering TRACK may be partial, so it is not judged
  assign line_err  = check_en && hs_edge && !first_q && (hcnt_inc != H_LEN);
  assign frame_err = check_en && vs_edge &&
                     ((vlen_meas != V_LEN) || err_seen_q || line_err || timeout);

  assign in_win    = (px >= X_FIRST) && (px <= X_LAST) &&
                     (vcnt_q >= Y_FIRST) && (vcnt_q <= Y_LAST);

  assign good_inc  = good_q + 1'b1;
  assign err_inc   = (errcnt_q == 8'hFF) ? 8'hFF : errcnt_q + 8'd1;

  // Sync sampling, position counters, length measurement and coordinate outputs
  always_ff @(posedge iclk or posedge iRST) begin
    if (iRST) begin
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      hlen_q     <= '0;
      vlen_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      active_q   <= 1'b0;
      err_seen_q <= 1'b0;
    end else begin
      hs_q   <= iHS;
      vs_q   <= iVS;
      hcnt_q <= hs_edge ? 10'd0 : hcnt_inc;
      if (vs_edge)      vcnt_q <= '0;
      else if (hs_edge) vcnt_q <= vcnt_inc;
      if (hs_edge) hlen_q <= hcnt_inc;
      if (vs_edge) vlen_q <= vlen_meas;
      if (vs_edge)                    err_seen_q <= 1'b0;
      else if (line_err || timeout)   err_seen_q <= 1'b1;
      x_q      <= in_win ? px - X_FIRST : 10'd0;
      y_q      <= in_win ? vcnt_q - Y_FIRST : 10'd0;
      // State only changes on edge/timeout samples, which lie outside the window
      active_q <= in_win && (state_q == LOCKED);
    end
  end

  // Lock FSM with registered lock flag, frame strobe and error counter
  always_ff @(posedge iclk or posedge iRST) begin
    if (iRST) begin
      state_q  <= SEARCH;
      good_q   <= '0;
      first_q  <= 1'b0;
      locked_q <= 1'b0;
      frame_q  <= 1'b0;
      errcnt_q <= '0;
    end else begin
      frame_q <= vs_edge && (state_q == LOCKED);
      if (hs_edge) first_q <= 1'b0;
      unique case (state_q)
        SEARCH: begin
          if (vs_edge) begin
            state_q <= TRACK;
            good_q  <= '0;
            first_q <= 1'b1;
          end
        end
        TRACK: begin
          if (timeout) begin
            state_q <= SEARCH;
            good_q  <= '0;
          end else if (vs_edge) begin
            if (frame_err) begin
              good_q <= '0;
            end else if (good_inc == GOOD_LOCK) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
              good_q   <= '0;
            end else begin
              good_q <= good_inc;
            end
          end
        end
        LOCKED: begin
          if (timeout) begin
            state_q  <= SEARCH;
            locked_q <= 1'b0;
            good_q   <= '0;
            errcnt_q <= err_inc;
          end else if (line_err || frame_err) begin
            state_q  <= TRACK;
            locked_q <= 1'b0;
            good_q   <= '0;
            first_q  <= 1'b1;
            errcnt_q <= err_inc;
          end
        end
        default: begin
          state_q  <= SEARCH;
          locked_q <= 1'b0;
          good_q   <= '0;
        end
      endcase
    end
  end

  assign oX      = x_q;
  assign oY      = y_q;
  assign oActive = active_q;
  assign oLocked = locked_q;
  assign oFrame  = frame_q;
  assign oHLen   = hlen_q;
  assign oVLen   = vlen_q;
  assign oErrCnt = errcnt_q;

endmodule
